// File: rtl/csc_nxn_if.sv
// Stream and coefficient bus of the N-channel colour-space converter.
interface csc_nxn_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 4
);
  logic            coef_wr;
  logic [AW-1:0]   coef_addr;
  logic [CW-1:0]   coef_wdata;
  logic [N*W-1:0]  x;
  logic [3:0]      x_mflags;
  logic [1:0]      x_sflags;
  logic [N*W-1:0]  y;
  logic [3:0]      y_mflags;
  logic [1:0]      y_sflags;

  // Producer / consumer side (drives samples and coefficients)
  modport master (
    output coef_wr, coef_addr, coef_wdata, x, x_mflags, y_sflags,
    input  x_sflags, y, y_mflags
  );

  // Converter side
  modport slave (
    input  coef_wr, coef_addr, coef_wdata, x, x_mflags, y_sflags,
    output x_sflags, y, y_mflags
  );
endinterface

// File: rtl/csc_nxn.sv
// N-channel colour-space converter: y = sat(round(A*x) + B), 3-stage stallable
// pipeline, shadow coefficient bank committed on an accepted start-of-frame beat.
module csc_nxn #(
  parameter int unsigned W    = 16,
  parameter int unsigned N    = 3,
  parameter int unsigned CW   = 16,
  parameter int unsigned FRAC = 12,
  parameter int unsigned AW   = $clog2(N*N+N)
) (
  input logic         clk,
  input logic         rst_n,
  csc_nxn_if.slave    bus
);
  localparam int unsigned NA  = N*N;
  localparam int unsigned NC  = NA + N;
  localparam int unsigned BW  = W + 1;
  localparam int unsigned PW  = W + CW + 1;
  // One extra bit over the product-sum width to hold the folded offset.
  localparam int unsigned SW  = PW + $clog2(N) + 1;
  localparam int unsigned AIW = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned BIW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [SW-1:0] RND  = SW'(1) << (FRAC-1);
  localparam logic signed [SW-1:0] YMAX = SW'({W{1'b1}});

  logic signed [CW-1:0] r_sh_a [NA];
  logic signed [CW-1:0] r_ac_a [NA];
  logic signed [BW-1:0] r_sh_b [N];
  logic signed [BW-1:0] r_ac_b [N];
  logic                 r_pend;

  logic signed [PW-1:0] r_p1 [NA];
  logic signed [BW-1:0] r_b1 [N];
  logic [3:0]           r_m1;
  logic signed [SW-1:0] r_s2 [N];
  logic [3:0]           r_m2;
  logic [N*W-1:0]       r_y;
  logic [3:0]           r_m3;

  logic                 w_rdy1, w_rdy2, w_rdy3, w_acc, w_commit, w_is_a, w_is_b;
  logic signed [CW-1:0] w_a [NA];
  logic signed [BW-1:0] w_b [N];
  logic signed [PW-1:0] w_p [NA];
  logic signed [SW-1:0] w_s [N];
  logic signed [SW-1:0] w_sh;
  logic [N*W-1:0]       w_y;
  logic                 w_unused;

  function automatic logic signed [CW-1:0] ident(input int unsigned k);
    return (k % (N + 1) == 0) ? CW'(1 << FRAC) : '0;
  endfunction

  // Stage occupancy chain: a stage loads when empty or when it drains this cycle
  assign w_rdy3   = ~r_m3[0] | ~bus.y_sflags[0];
  assign w_rdy2   = ~r_m2[0] | w_rdy3;
  assign w_rdy1   = ~r_m1[0] | w_rdy2;
  assign w_acc    = bus.x_mflags[0] & w_rdy1;
  assign w_commit = w_acc & bus.x_mflags[1];
  assign w_is_a   = {1'b0, bus.coef_addr} < (AW+1)'(NA);
  assign w_is_b   = ~w_is_a & ({1'b0, bus.coef_addr} < (AW+1)'(NC));
  assign w_unused = bus.y_sflags[1];

  assign bus.x_sflags = {r_pend, r_m1[0] & ~w_rdy2};
  assign bus.y        = r_y;
  assign bus.y_mflags = r_m3;

  // Shadow/active banks; a write coincident with a commit lands only in the shadow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NA; k++) begin
        r_sh_a[AIW'(k)] <= ident(k);
        r_ac_a[AIW'(k)] <= ident(k);
      end
      for (int unsigned k = 0; k < N; k++) begin
        r_sh_b[BIW'(k)] <= '0;
        r_ac_b[BIW'(k)] <= '0;
      end
      r_pend <= 1'b0;
    end else begin
      if (w_commit) begin
        r_ac_a <= r_sh_a;
        r_ac_b <= r_sh_b;
      end
      if (bus.coef_wr && w_is_a)
        r_sh_a[AIW'(bus.coef_addr)] <= $signed(bus.coef_wdata);
      if (bus.coef_wr && w_is_b)
        r_sh_b[BIW'(bus.coef_addr - AW'(NA))] <= BW'($signed(bus.coef_wdata));
      if (bus.coef_wr)
        r_pend <= 1'b1;
      else if (w_commit)
        r_pend <= 1'b0;
    end
  end

  // Coefficients seen by the incoming beat: the committing beat already uses the shadow
  always_comb begin
    w_a = r_ac_a;
    w_b = r_ac_b;
    if (w_commit) begin
      w_a = r_sh_a;
      w_b = r_sh_b;
    end
  end

  // Signed coefficient times zero-extended sample
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        w_p[AIW'(i*N+j)] = PW'(w_a[AIW'(i*N+j)]) * PW'($signed({1'b0, bus.x[j*W +: W]}));
      end
    end
  end

  // S1: products plus the beat's offsets, so a later commit cannot touch this beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m1 <= '0;
    end else if (w_rdy1) begin
      r_m1 <= bus.x_mflags[0] ? bus.x_mflags : 4'b0000;
      if (bus.x_mflags[0]) begin
        r_p1 <= w_p;
        r_b1 <= w_b;
      end
    end
  end

  // Row sums; offset pre-scaled by 2^FRAC is exact under the later shift
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_s[BIW'(i)] = (SW'(r_b1[BIW'(i)]) <<< FRAC) + RND;
      for (int unsigned j = 0; j < N; j++) begin
        w_s[BIW'(i)] = w_s[BIW'(i)] + SW'(r_p1[AIW'(i*N+j)]);
      end
    end
  end

  // S2: registered sums
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m2 <= '0;
    end else if (w_rdy2) begin
      r_m2 <= r_m1;
      if (r_m1[0]) r_s2 <= w_s;
    end
  end

  // Drop fraction (round half up already added) and clamp to [0, 2^W-1]
  always_comb begin
    w_y  = '0;
    w_sh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sh = r_s2[BIW'(i)] >>> FRAC;
      if (w_sh[SW-1])
        w_y[i*W +: W] = '0;
      else if (w_sh > YMAX)
        w_y[i*W +: W] = '1;
      else
        w_y[i*W +: W] = W'(w_sh);
    end
  end

  // S3: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m3 <= '0;
      r_y  <= '0;
    end else if (w_rdy3) begin
      r_m3 <= r_m2;
      if (r_m2[0]) r_y <= w_y;
    end
  end
endmodule
